fetch_unit: RTL
===============

# fetch_unit

Instruction-fetch stage of the RV32I pipeline, upstream of the branch unit. Holds the program counter and drives a request/ready handshake to instruction memory. Writes fetched instructions into the IF/ID pipeline register. Consumes the branch unit's redirect pair (BrPC, PcSel) to retarget the PC and flush wrong-path work, and honours the hazard unit's stall.

## Interface
- PC_W, 9: PC / instruction-address width in bits, byte address.
- INS_W, 32: instruction width.

- clk  in  1  single clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high.
- PcSel  in  1  redirect request from the branch unit; 1 = load BrPC.
- BrPC  in  32  redirect target; only bits [PC_W-1:2] are used.
- Stall  in  1  hazard-unit stall; 1 = IF/ID must hold.
- imem_req  out  1  fetch request valid.
- imem_addr  out  PC_W  fetch byte address; equals the PC register.
- imem_ready  in  1  memory accepts the request and returns data in the same cycle.
- imem_rdata  in  INS_W  instruction; valid when imem_req && imem_ready.
- IfId_PC  out  PC_W  PC of the instruction held in IF/ID.
- IfId_Instr  out  INS_W  instruction held in IF/ID.
- IfId_Valid  out  1  IF/ID holds a real instruction; 0 = bubble.

## Operation
- States:
  - IDLE: entered only via reset.
  - REQ: request outstanding.
  - HOLD: fetched word parked in the skid buffer because of a stall.
  - DROP: in-flight response to be discarded after a redirect.
- Handshake: while imem_req=1, imem_addr stays stable until imem_ready=1. The request is never withdrawn before ready.
- IDLE → REQ on the first clock edge after reset deasserts.
- REQ, accept (req && ready), PcSel=0, Stall=0:
  - IF/ID loads {PC, imem_rdata, Valid=1}.
  - PC ← PC+4.
  - Stay in REQ. Back-to-back fetch gives 1 instruction per cycle.
- REQ, accept, PcSel=0, Stall=1:
  - The word and its PC go to the skid buffer; IF/ID holds.
  - PC ← PC+4; go to HOLD.
- HOLD: imem_req=0.
  - When Stall=0: IF/ID loads the skid buffer with Valid=1, then go to REQ.
  - While Stall=1: IF/ID and the skid buffer hold.
- Redirect (PcSel=1) has priority over Stall and over everything else:
  - PC ← {BrPC[PC_W-1:2], 2'b00}. Upper and low BrPC bits are ignored.
  - IfId_Valid ← 0. IfId_PC and IfId_Instr may keep stale values.
  - The skid buffer is discarded.
  - From REQ with an accept that same cycle: the data is discarded; stay in REQ at the new PC.
  - From REQ without an accept: go to DROP. imem_addr keeps the old address until ready.
  - From HOLD: go to REQ.
  - From DROP: the target is overwritten; the latest redirect wins.
- DROP: imem_req=1 at the old address. On ready, the data is discarded, imem_addr switches to the PC register (the redirect target), and the state goes to REQ.
  - The old address is kept in a separate register; imem_addr is muxed from it while in DROP.
- Stall with IfId_Valid=0 still holds the bubble. A bubble is never overwritten while Stall=1.
- PC arithmetic is modulo 2^PC_W: PC = 2^PC_W-4 plus 4 wraps to 0.
- A halt arrives as PcSel=1 with BrPC equal to the halting instruction's PC. This block treats it as an ordinary redirect, so fetch spins on that address.

## Timing
- Reset (asynchronous, immediate):
  - state = IDLE, PC = 0, imem_req = 0, imem_addr = 0.
  - IfId_PC = 0, IfId_Instr = 0, IfId_Valid = 0, skid buffer empty.
- First request: imem_req=1 with imem_addr=0 in the first cycle after the first post-reset edge.
- Fetch latency: an instruction accepted at edge N is visible on IfId_* after edge N.
- Redirect latency: PcSel sampled at edge N.
  - No request outstanding, or accepted at N: imem_addr = target after edge N.
  - Not accepted at N (→ DROP): the target is issued the cycle after the pending ready.
- Reset asserted mid-operation (any state, including DROP or HOLD): all of the above return to reset values immediately. A pending memory response is not tracked.

## Test plan
- Reset release, imem_ready tied 1: imem_addr = 0, 4, 8, ... on consecutive cycles; IfId_Valid rises one cycle after the first request; IfId_PC lags imem_addr by one cycle.
- Stall=1 for 3 cycles while a word (0x00A00093 at PC 0x010) is accepted: IF/ID holds its prior contents, imem_req=0 during HOLD; on release IF/ID = {0x010, 0x00A00093, 1}, next request address 0x014.
- PcSel=1 with BrPC=0x0000_0043 while imem_ready=1: next imem_addr = 0x040; IfId_Valid = 0 for one cycle; the word fetched in the redirect cycle never appears in IF/ID.
- imem_ready low for 4 cycles at address 0x020, PcSel pulsed in cycle 2 with BrPC=0x100: imem_addr stays 0x020 until ready; that data is dropped; next request address = 0x100.
- PC wrap: run from 0x1F8 with ready=1: addresses 0x1F8, 0x1FC, 0x000; PcSel and Stall asserted together → flush wins, IfId_Valid = 0.
- Assert reset while in DROP: all outputs return to reset values the same cycle; after release, the fetch sequence restarts at 0x000.

Source files
------------

// File: rtl/fetch_unit_if.sv
// Instruction-memory port of the fetch stage.
// Handshake: the fetch side raises imem_req with a stable imem_addr and keeps
// both unchanged until imem_ready=1; the transfer happens on the rising edge
// where imem_req && imem_ready, and imem_rdata is valid in that same cycle.
interface fetch_unit_if #(
    parameter int PC_W  = 9,
    parameter int INS_W = 32
);
    logic             imem_req;
    logic [PC_W-1:0]  imem_addr;
    logic             imem_ready;
    logic [INS_W-1:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ready,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ready,
        output imem_rdata
    );
endinterface

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, requests words from instruction
// memory, fills the IF/ID register, parks a word in a skid buffer on stall,
// and discards wrong-path work on a branch-unit redirect.
module fetch_unit #(
    parameter int PC_W  = 9,
    parameter int INS_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              PcSel,
    input  logic [31:0]       BrPC,
    input  logic              Stall,
    fetch_unit_if.master      imem,
    output logic [PC_W-1:0]   IfId_PC,
    output logic [INS_W-1:0]  IfId_Instr,
    output logic              IfId_Valid,
    output logic [1:0]        dbg_state
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_HOLD = 2'd2,
        S_DROP = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [PC_W-1:0]  pc_q, pc_d;
    logic [PC_W-1:0]  old_addr_q, old_addr_d;
    logic [PC_W-1:0]  skid_pc_q, skid_pc_d;
    logic [INS_W-1:0] skid_instr_q, skid_instr_d;
    logic [PC_W-1:0]  ifid_pc_q, ifid_pc_d;
    logic [INS_W-1:0] ifid_instr_q, ifid_instr_d;
    logic             ifid_valid_q, ifid_valid_d;

    logic             accept;
    logic [PC_W-1:0]  redirect_pc;
    logic             unused_brpc_bits;

    // Redirect targets are word aligned and confined to the PC range.
    assign redirect_pc      = {BrPC[PC_W-1:2], 2'b00};
    assign unused_brpc_bits = ^{BrPC[31:PC_W], BrPC[1:0]};

    // While DROP waits out the stale response the old address must stay on the bus.
    assign imem.imem_req  = (state_q == S_REQ) || (state_q == S_DROP);
    assign imem.imem_addr = (state_q == S_DROP) ? old_addr_q : pc_q;
    assign accept         = imem.imem_req && imem.imem_ready;

    assign IfId_PC    = ifid_pc_q;
    assign IfId_Instr = ifid_instr_q;
    assign IfId_Valid = ifid_valid_q;
    assign dbg_state  = state_q;

    // Next-state, PC, skid buffer and IF/ID update; redirect overrides everything.
    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        old_addr_d   = old_addr_q;
        skid_pc_d    = skid_pc_q;
        skid_instr_d = skid_instr_q;
        ifid_pc_d    = ifid_pc_q;
        ifid_instr_d = ifid_instr_q;
        ifid_valid_d = ifid_valid_q;

        if (PcSel) begin
            pc_d         = redirect_pc;
            ifid_valid_d = 1'b0;
            case (state_q)
                S_REQ: begin
                    if (!accept) begin
                        old_addr_d = pc_q;
                        state_d    = S_DROP;
                    end
                end
                S_DROP: begin
                    if (accept) state_d = S_REQ;
                end
                default: state_d = S_REQ;
            endcase
        end else begin
            case (state_q)
                S_IDLE: state_d = S_REQ;
                S_REQ: begin
                    if (accept) begin
                        pc_d = pc_q + PC_W'(4);
                        if (Stall) begin
                            skid_pc_d    = pc_q;
                            skid_instr_d = imem.imem_rdata;
                            state_d      = S_HOLD;
                        end else begin
                            ifid_pc_d    = pc_q;
                            ifid_instr_d = imem.imem_rdata;
                            ifid_valid_d = 1'b1;
                        end
                    end else if (!Stall) begin
                        // Nothing arrived and decode moves on: present a bubble.
                        ifid_valid_d = 1'b0;
                    end
                end
                S_HOLD: begin
                    if (!Stall) begin
                        ifid_pc_d    = skid_pc_q;
                        ifid_instr_d = skid_instr_q;
                        ifid_valid_d = 1'b1;
                        state_d      = S_REQ;
                    end
                end
                S_DROP: begin
                    if (!Stall) ifid_valid_d = 1'b0;
                    if (accept) state_d = S_REQ;
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    // State registers with asynchronous reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= S_IDLE;
            pc_q         <= '0;
            old_addr_q   <= '0;
            skid_pc_q    <= '0;
            skid_instr_q <= '0;
            ifid_pc_q    <= '0;
            ifid_instr_q <= '0;
            ifid_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            old_addr_q   <= old_addr_d;
            skid_pc_q    <= skid_pc_d;
            skid_instr_q <= skid_instr_d;
            ifid_pc_q    <= ifid_pc_d;
            ifid_instr_q <= ifid_instr_d;
            ifid_valid_q <= ifid_valid_d;
        end
    end

endmodule
